// File: rtl/bitswap_pkg.sv
// bitswap_pkg: shared types and constants for the bit-permuting round-robin scheduler.
// Rev 1.0
`default_nettype none

package bitswap_pkg;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        SWAP = 2'd1,
        REV  = 2'd2,
        ROTL = 2'd3
    } mode_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int XFER_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/bitswap_rr_arb.sv
// bitswap_rr_arb: combinational round-robin arbiter, searching upward from ptr_i modulo N.
// Rev 1.0
`default_nettype none

module bitswap_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    localparam int CW = IW + 1;

    logic          found;
    logic [CW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // Wrap explicitly so non-power-of-two N never indexes past the last requester.
            cand = {1'b0, ptr_i} + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found                   = 1'b1;
                gnt_o[cand[IW-1:0]]     = 1'b1;
                idx_o                   = cand[IW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bitswap_sched.sv
// bitswap_sched: round-robin scheduler that permutes the granted word and holds it
// in a single output slot with full-throughput handshake.  Rev 1.0
`default_nettype none

module bitswap_sched
    import bitswap_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    input  logic [NREQ*2-1:0]         req_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic [XFER_CNT_W-1:0]     xfer_cnt
);

    localparam int IW = $clog2(NREQ);

    function automatic logic [WIDTH-1:0] perm(input logic [WIDTH-1:0] d, input mode_e m);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            PASS: r = d;
            SWAP: begin
                for (int k = 0; k < WIDTH / 2; k++) begin
                    r[2*k]   = d[2*k+1];
                    r[2*k+1] = d[2*k];
                end
            end
            REV: begin
                for (int j = 0; j < WIDTH; j++) begin
                    r[j] = d[WIDTH-1-j];
                end
            end
            ROTL: r = {d[WIDTH-2:0], d[WIDTH-1]};
            default: r = d;
        endcase
        return r;
    endfunction

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [IW-1:0]           id_q, id_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [XFER_CNT_W-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]         w_gnt;
    logic [IW-1:0]           w_idx;
    logic                    w_free;
    logic                    w_grant;
    logic                    w_xfer;
    logic [WIDTH-1:0]        w_sel_data;
    mode_e                   w_sel_mode;

    bitswap_rr_arb #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (w_gnt),
        .idx_o (w_idx)
    );

    assign w_xfer     = (state_q == HOLD) && out_ready;
    assign w_free     = (state_q == IDLE) || out_ready;
    assign w_grant    = en && w_free && (|req_valid);
    assign w_sel_data = req_data[int'(w_idx)*WIDTH +: WIDTH];
    assign w_sel_mode = mode_e'(req_mode[int'(w_idx)*2 +: 2]);

    // Gated by rst_n so no requester sees an accept while reset is held.
    assign req_ready  = (w_grant && rst_n) ? w_gnt : '0;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (w_xfer) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (w_grant) begin
            state_d = HOLD;
            data_d  = perm(w_sel_data, w_sel_mode);
            id_d    = w_idx;
            ptr_d   = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        end else if (w_xfer) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign xfer_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bitswap_sched.sv
// tb_bitswap_sched: directed scoreboard bench for bitswap_sched (NREQ=4, WIDTH=32).
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_bitswap_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*2-1:0]     req_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_id;
    logic [15:0]           xfer_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [33:0] sb[$];

    bitswap_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_mode  (req_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        r = d;
        for (int j = 0; j < 32; j++) begin
            case (m)
                2'd1:    r[j] = d[j ^ 1];
                2'd2:    r[j] = d[31 - j];
                2'd3:    r[j] = d[(j + 31) % 32];
                default: r[j] = d[j];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [31:0] d, input logic [1:0] m);
        req_data[i*32 +: 32] = d;
        req_mode[i*2 +: 2]   = m;
    endtask

    task automatic push(input int i);
        sb.push_back({2'(i), model(req_data[i*32 +: 32], req_mode[i*2 +: 2])});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [33:0] e;
            chk("sb_depth", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(e[31:0]));
                chk("out_id", 64'(out_id), 64'(e[33:32]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_word;
        int          exp_ptr;

        rst_n = 1'b0; en = 1'b0; req_valid = '0; req_data = '0; req_mode = '0; out_ready = 1'b0;

        // Reset state, with requests pending that must not be accepted
        step();
        en = 1'b1; req_valid = 4'hF;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        step();
        req_valid = '0; rst_n = 1'b1;

        // Single requester, SWAP
        out_ready = 1'b1;
        drive(0, 32'hAAAA_AAAA, 2'd1);
        req_valid = 4'b0001;
        push(0);
        #1 chk("swap_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        chk("swap_valid", 64'(out_valid), 64'd1);
        chk("swap_data", 64'(out_data), 64'h5555_5555);
        chk("swap_id", 64'(out_id), 64'd0);
        step();
        chk("swap_cnt", 64'(xfer_cnt), 64'd1);
        chk("swap_idle", 64'(out_valid), 64'd0);

        // REV, ROTL, PASS back to back
        drive(1, 32'h0000_0001, 2'd2); req_valid = 4'b0010; push(1);
        #1 chk("rev_ready", 64'(req_ready), 64'h2);
        step();
        chk("rev_data", 64'(out_data), 64'h8000_0000);
        drive(2, 32'h8000_0001, 2'd3); req_valid = 4'b0100; push(2);
        #1 chk("rotl_ready", 64'(req_ready), 64'h4);
        step();
        chk("rotl_data", 64'(out_data), 64'h0000_0003);
        drive(3, 32'h1234_5678, 2'd0); req_valid = 4'b1000; push(3);
        #1 chk("pass_ready", 64'(req_ready), 64'h8);
        step();
        chk("pass_data", 64'(out_data), 64'h1234_5678);
        req_valid = '0;
        step();
        chk("modes_cnt", 64'(xfer_cnt), 64'd4);

        // All requesters valid: round-robin 0,1,2,3,0
        drive(0, 32'h0F0F_0F0F, 2'd1);
        drive(1, 32'h1111_2222, 2'd2);
        drive(2, 32'hC000_0001, 2'd3);
        drive(3, 32'hDEAD_BEEF, 2'd0);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            push(k % 4);
            #1 chk("rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
            step();
        end
        req_valid = '0;
        step();
        chk("rr_cnt", 64'(xfer_cnt), 64'd9);
        chk("rr_idle", 64'(out_valid), 64'd0);

        // Back-pressure: held word stable, mode change after grant ignored
        out_ready = 1'b0;
        req_valid = 4'b0100;
        push(2);
        exp_word = model(32'hC000_0001, 2'd3);
        step();
        req_valid = 4'hF;
        req_mode[5:4] = 2'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 64'(req_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(exp_word));
            chk("stall_id", 64'(out_id), 64'd2);
            step();
        end
        out_ready = 1'b1;
        #1 chk("unstall_ready", 64'(req_ready), 64'h8);
        push(3);
        step();
        req_valid = '0;
        chk("unstall_id", 64'(out_id), 64'd3);
        chk("unstall_data", 64'(out_data), 64'hDEAD_BEEF);
        step();
        chk("unstall_cnt", 64'(xfer_cnt), 64'd11);

        // en dropped during HOLD: word drains, no new grant
        out_ready = 1'b0;
        req_valid = 4'b0001;
        push(0);
        step();
        en = 1'b0; out_ready = 1'b1; req_valid = 4'hF;
        #1 chk("en_off_ready", 64'(req_ready), 64'd0);
        step();
        chk("en_off_valid", 64'(out_valid), 64'd0);
        chk("en_off_cnt", 64'(xfer_cnt), 64'd12);
        step();
        chk("en_off_still_idle", 64'(out_valid), 64'd0);
        chk("en_off_ready2", 64'(req_ready), 64'd0);
        req_valid = '0; en = 1'b1;

        // Reset mid-HOLD discards the word and clears pointer and count
        out_ready = 1'b0;
        req_valid = 4'b0010;
        step();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_id", 64'(out_id), 64'd0);
        chk("arst_cnt", 64'(xfer_cnt), 64'd0);
        chk("arst_ready", 64'(req_ready), 64'd0);
        step();
        rst_n = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
        #1 chk("post_rst_ptr", 64'(req_ready), 64'h1);
        push(0);
        step();
        req_valid = '0;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_id", 64'(out_id), 64'd0);
        step();
        chk("post_rst_cnt", 64'(xfer_cnt), 64'd1);

        // Stream up to 16'hFFFF, then one more handshake wraps to zero
        req_valid = 4'hF;
        exp_ptr = 1;
        for (int n = 0; n < 65534; n++) begin
            push(exp_ptr);
            step();
            exp_ptr = (exp_ptr + 1) % 4;
        end
        req_valid = '0;
        step();
        chk("cnt_max", 64'(xfer_cnt), 64'hFFFF);
        req_valid = 4'hF;
        push(exp_ptr);
        step();
        req_valid = '0;
        step();
        chk("cnt_wrap", 64'(xfer_cnt), 64'h0);

        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
